// File: rtl/rip_regfile_mp.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Reads are registered one cycle; same-cycle writes can be forwarded to reads.
module rip_regfile_mp #(
    parameter int unsigned      XLEN    = 32,
    parameter int unsigned      NREG    = 32,
    parameter int unsigned      NRD     = 2,
    parameter int unsigned      NWR     = 1,
    parameter logic [XLEN-1:0]  SP_INIT = 32'h0001_0000,
    parameter bit               BYPASS  = 1'b1,
    localparam int unsigned     AW      = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NWR-1:0]       wen,
    input  logic [NWR*AW-1:0]    wr_num,
    input  logic [NWR*XLEN-1:0]  wdata,
    input  logic [NRD*AW-1:0]    rd_num,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_num,
    output logic [NREG-1:0]      busy_vec
);

    // Architectural state plus registered read results.
    logic [XLEN-1:0] regs_q  [NREG];
    logic [XLEN-1:0] regs_d  [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [XLEN-1:0] rdata_q [NRD];
    logic [XLEN-1:0] rdata_d [NRD];
    logic [NRD-1:0]  rd_busy_q;
    logic [NRD-1:0]  rd_busy_d;

    // Per-register decode of write ports and the scoreboard set request.
    logic [NWR-1:0]  wr_hit_s [NREG];
    logic [NREG-1:0] sb_hit_s;

    // An index is readable when it names a real register other than x0.
    function automatic logic idx_ok(input logic [AW-1:0] idx);
        return (idx != {AW{1'b0}}) && (32'(idx) < NREG);
    endfunction

    // Decode which write ports and which set request target each register.
    always_comb begin
        wr_hit_s[0] = {NWR{1'b0}};
        sb_hit_s    = {NREG{1'b0}};
        for (int i = 1; i < NREG; i++) begin
            for (int p = 0; p < NWR; p++) begin
                wr_hit_s[i][p] = wen[p] && (wr_num[p*AW +: AW] == AW'(i));
            end
            sb_hit_s[i] = sb_set && (sb_num == AW'(i));
        end
    end

    // Next register contents and busy bits; later ports override earlier ones
    // and a set request beats a clear on the same register.
    always_comb begin
        regs_d[0] = {XLEN{1'b0}};
        busy_d    = {NREG{1'b0}};
        for (int i = 1; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            busy_d[i] = busy_q[i];
            for (int p = 0; p < NWR; p++) begin
                regs_d[i] = wr_hit_s[i][p] ? wdata[p*XLEN +: XLEN] : regs_d[i];
                busy_d[i] = wr_hit_s[i][p] ? 1'b0 : busy_d[i];
            end
            busy_d[i] = sb_hit_s[i] ? 1'b1 : busy_d[i];
        end
    end

    // Read ports see post-update state when forwarding, stored state otherwise.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            if (idx_ok(rd_num[k*AW +: AW])) begin
                rdata_d[k]   = BYPASS ? regs_d[rd_num[k*AW +: AW]]
                                      : regs_q[rd_num[k*AW +: AW]];
                rd_busy_d[k] = BYPASS ? busy_d[rd_num[k*AW +: AW]]
                                      : busy_q[rd_num[k*AW +: AW]];
            end else begin
                rdata_d[k]   = {XLEN{1'b0}};
                rd_busy_d[k] = 1'b0;
            end
        end
    end

    // State registers with synchronous reset; sp comes up at SP_INIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == 32'sd2) ? SP_INIT : {XLEN{1'b0}};
            end
            busy_q    <= {NREG{1'b0}};
            for (int k = 0; k < NRD; k++) begin
                rdata_q[k] <= {XLEN{1'b0}};
            end
            rd_busy_q <= {NRD{1'b0}};
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q    <= busy_d;
            for (int k = 0; k < NRD; k++) begin
                rdata_q[k] <= rdata_d[k];
            end
            rd_busy_q <= rd_busy_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd_flat
        assign rdata[k*XLEN +: XLEN] = rdata_q[k];
    end

    assign rd_busy  = rd_busy_q;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_rip_regfile_mp.sv
// Bench for rip_regfile_mp: a forwarding and a non-forwarding instance share
// stimulus and are checked every cycle against an array-based reference model.
module tb_rip_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [1:0]  wen;
    logic [9:0]  wr_num;
    logic [63:0] wdata;
    logic [9:0]  rd_num;
    logic        sb_set;
    logic [4:0]  sb_num;

    logic [63:0] rdata_b, rdata_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic [31:0] busy_vec_b, busy_vec_n;

    rip_regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2),
                     .SP_INIT(32'h0001_0000), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wr_num(wr_num), .wdata(wdata),
        .rd_num(rd_num), .rdata(rdata_b), .rd_busy(rd_busy_b),
        .sb_set(sb_set), .sb_num(sb_num), .busy_vec(busy_vec_b));

    rip_regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2),
                     .SP_INIT(32'h0001_0000), .BYPASS(1'b0)) u_nob (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wr_num(wr_num), .wdata(wdata),
        .rd_num(rd_num), .rdata(rdata_n), .rd_busy(rd_busy_n),
        .sb_set(sb_set), .sb_num(sb_num), .busy_vec(busy_vec_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [32];
    logic [31:0] busy;
    logic [31:0] exp_rd_b [2];
    logic [31:0] exp_rd_n [2];
    logic [1:0]  exp_bz_b;
    logic [1:0]  exp_bz_n;
    logic [31:0] exp_bv;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare both DUTs.
    task automatic cyc(input logic rn, input logic [1:0] we,
                       input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic ss, input logic [4:0] sn);
        logic [31:0] nmem [32];
        logic [31:0] nbusy;
        logic [4:0]  wa [2];
        logic [31:0] wd [2];
        logic [4:0]  ra [2];
        rst_n  = rn;   wen = we;
        wr_num = {a1, a0}; wdata = {d1, d0};
        rd_num = {r1, r0};
        sb_set = ss;   sb_num = sn;
        wa[0] = a0; wa[1] = a1; wd[0] = d0; wd[1] = d1; ra[0] = r0; ra[1] = r1;
        if (!rn) begin
            for (int i = 0; i < 32; i++) mem[i] = (i == 2) ? 32'h0001_0000 : 32'h0;
            busy = 32'h0;
            for (int k = 0; k < 2; k++) begin
                exp_rd_b[k] = 32'h0; exp_rd_n[k] = 32'h0;
            end
            exp_bz_b = 2'b00; exp_bz_n = 2'b00; exp_bv = 32'h0;
        end else begin
            nmem = mem; nbusy = busy;
            for (int p = 0; p < 2; p++) begin
                if (we[p] && wa[p] != 5'd0) begin
                    nmem[wa[p]]  = wd[p];
                    nbusy[wa[p]] = 1'b0;
                end
            end
            if (ss && sn != 5'd0) nbusy[sn] = 1'b1;
            for (int k = 0; k < 2; k++) begin
                exp_rd_b[k] = (ra[k] == 5'd0) ? 32'h0 : nmem[ra[k]];
                exp_rd_n[k] = (ra[k] == 5'd0) ? 32'h0 : mem[ra[k]];
                exp_bz_b[k] = (ra[k] == 5'd0) ? 1'b0 : nbusy[ra[k]];
                exp_bz_n[k] = (ra[k] == 5'd0) ? 1'b0 : busy[ra[k]];
            end
            exp_bv = nbusy;
            mem = nmem; busy = nbusy;
        end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("byp_rdata%0d", k), 64'(rdata_b[k*32 +: 32]), 64'(exp_rd_b[k]));
            check($sformatf("nob_rdata%0d", k), 64'(rdata_n[k*32 +: 32]), 64'(exp_rd_n[k]));
            check($sformatf("byp_rd_busy%0d", k), 64'(rd_busy_b[k]), 64'(exp_bz_b[k]));
            check($sformatf("nob_rd_busy%0d", k), 64'(rd_busy_n[k]), 64'(exp_bz_n[k]));
        end
        check("byp_busy_vec", 64'(busy_vec_b), 64'(exp_bv));
        check("nob_busy_vec", 64'(busy_vec_n), 64'(exp_bv));
    endtask

    task automatic rd(input logic [4:0] r0, input logic [4:0] r1);
        cyc(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, r0, r1, 1'b0, 5'd0);
    endtask

    initial begin
        // reset and read every register
        cyc(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        cyc(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        for (int r = 0; r < 32; r++) begin
            rd(5'(r), 5'(31 - r));
            if (r == 2) check("lit_sp_reset", 64'(rdata_b[31:0]), 64'h0001_0000);
        end

        // write then read one cycle later
        cyc(1'b1, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        rd(5'd5, 5'd5);
        check("lit_x5_read", 64'(rdata_n[63:32]), 64'h0000_0000_DEAD_BEEF);

        // same-cycle write and read: forwarded vs. old value
        cyc(1'b1, 2'b01, 5'd7, 32'h1234, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0);
        check("lit_x7_byp", 64'(rdata_b[31:0]), 64'h1234);
        check("lit_x7_nob", 64'(rdata_n[31:0]), 64'h0);
        rd(5'd7, 5'd2);

        // both ports target x9: highest port wins
        cyc(1'b1, 2'b11, 5'd9, 32'hAAAA, 5'd9, 32'hBBBB, 5'd9, 5'd9, 1'b0, 5'd0);
        check("lit_x9_byp", 64'(rdata_b[63:32]), 64'hBBBB);
        rd(5'd9, 5'd5);
        check("lit_x9_nob", 64'(rdata_n[31:0]), 64'hBBBB);

        // scoreboard: set, clear by write, then set+write same cycle
        cyc(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b1, 5'd3);
        check("lit_busy3_set", 64'(busy_vec_b[3]), 64'h1);
        check("lit_rdbusy_byp", 64'(rd_busy_b[0]), 64'h1);
        check("lit_rdbusy_nob", 64'(rd_busy_n[0]), 64'h0);
        cyc(1'b1, 2'b10, 5'd0, 32'h0, 5'd3, 32'h33, 5'd3, 5'd3, 1'b0, 5'd0);
        check("lit_busy3_clr", 64'(busy_vec_n[3]), 64'h0);
        check("lit_rdbusy_nob_pre", 64'(rd_busy_n[1]), 64'h1);
        cyc(1'b1, 2'b01, 5'd3, 32'h44, 5'd0, 32'h0, 5'd3, 5'd0, 1'b1, 5'd3);
        check("lit_busy3_setwins", 64'(busy_vec_b[3]), 64'h1);
        rd(5'd3, 5'd3);

        // mixed traffic on both ports with rolling busy marks
        for (int i = 1; i < 16; i++) begin
            cyc(1'b1, 2'(i % 4), 5'(i), 32'(i) * 32'h0101_0101,
                5'(i + 16), ~(32'(i) * 32'h0001_0003),
                5'(i - 1), 5'(i + 15), 1'b1, 5'(i + 1));
        end
        for (int r = 0; r < 32; r += 2) rd(5'(r), 5'(r + 1));

        // x0 write and set are ignored
        cyc(1'b1, 2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFF, 5'd0, 5'd0, 1'b1, 5'd0);
        check("lit_x0_read", 64'(rdata_b[31:0]), 64'h0);
        check("lit_x0_busy", 64'(busy_vec_b[0]), 64'h0);

        // reset in the middle of traffic overrides everything
        cyc(1'b1, 2'b01, 5'd10, 32'hCAFE, 5'd0, 32'h0, 5'd10, 5'd12, 1'b1, 5'd12);
        cyc(1'b0, 2'b11, 5'd10, 32'h5555, 5'd11, 32'h6666, 5'd10, 5'd11, 1'b1, 5'd11);
        check("lit_rst_busy", 64'(busy_vec_b), 64'h0);
        check("lit_rst_rdata", rdata_b, 64'h0);
        for (int r = 0; r < 32; r++) begin
            rd(5'(r), 5'(r));
            if (r == 5) check("lit_x5_after_rst", 64'(rdata_n[31:0]), 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
